// File: rtl/axis_fifo_pkg.sv
// rtl/axis_fifo_pkg.sv - shared types and pointer helpers for the AXI-Stream frame FIFO
package axis_fifo_pkg;

  typedef enum logic [0:0] {
    WR_ACTIVE = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_t;

  localparam int unsigned PTR_MAX_W = 32;

  // Wrapped subtraction of two w-bit pointers carried in a wide container.
  function automatic logic [PTR_MAX_W-1:0] ptr_diff(
    input logic [PTR_MAX_W-1:0] a,
    input logic [PTR_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic [PTR_MAX_W-1:0] mask;
    mask = (PTR_MAX_W'(1) << w) - PTR_MAX_W'(1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // No reset so the array maps onto block RAM; read data holds while rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_frame_fifo.sv
// rtl/axis_frame_fifo.sv - store-and-forward frame FIFO with FCS trim, bad/runt rewind
// and overflow handling for the Ethernet RX path.
module axis_frame_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 1024,
  parameter int TRIM_BEATS     = 4,
  parameter bit DROP_WHEN_FULL = 1'b1,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   frame_count,
  output logic                  good_frame,
  output logic                  bad_frame,
  output logic                  overflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int CNT_W = $clog2(TRIM_BEATS + 2);

  wr_state_t             state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         fetch_ptr_q, fetch_ptr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DEPTH-1:0]      last_q, last_d;
  logic [PW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
  logic                  ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic                  out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [PW-1:0]         used, commit_next, last_ptr;
  logic                  full, runt, accept, ram_we, commit;
  logic                  pop, load_out, rd_en;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign used        = PW'(ptr_diff(PTR_MAX_W'(wr_ptr_q), PTR_MAX_W'(rd_ptr_q), PW));
  assign full        = (used == PW'(DEPTH));
  assign commit_next = wr_ptr_q + PW'(1) - PW'(TRIM_BEATS);
  assign last_ptr    = wr_ptr_q - PW'(TRIM_BEATS);
  assign runt        = (beat_cnt_q < CNT_W'(TRIM_BEATS));

  // Backpressure mode still opens tready when full with nothing committed, else an oversize frame deadlocks.
  assign s_axis_tready = DROP_WHEN_FULL ? 1'b1 :
                         ((state_q == WR_DROP) || !full || (frame_cnt_q == '0));
  assign accept = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    last_d       = last_q;
    good_d       = 1'b0;
    bad_d        = 1'b0;
    ovf_d        = 1'b0;
    ram_we       = 1'b0;
    commit       = 1'b0;
    if (accept) begin
      if (state_q == WR_DROP) begin
        if (s_axis_tlast) state_d = WR_ACTIVE;
      end else if (full) begin
        wr_ptr_d   = commit_ptr_q;
        beat_cnt_d = '0;
        ovf_d      = 1'b1;
        if (!s_axis_tlast) state_d = WR_DROP;
      end else begin
        ram_we                         = 1'b1;
        wr_ptr_d                       = wr_ptr_q + PW'(1);
        last_d[wr_ptr_q[ADDR_WIDTH-1:0]] = 1'b0;
        if (beat_cnt_q != CNT_W'(TRIM_BEATS + 1)) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (s_axis_tlast) begin
          beat_cnt_d = '0;
          if (s_axis_tuser || runt) begin
            wr_ptr_d = commit_ptr_q;
            bad_d    = 1'b1;
          end else begin
            // Set after the clear above so TRIM_BEATS=0 keeps tlast on the beat just written.
            last_d[last_ptr[ADDR_WIDTH-1:0]] = 1'b1;
            commit_ptr_d = commit_next;
            wr_ptr_d     = commit_next;
            good_d       = 1'b1;
            commit       = 1'b1;
          end
        end
      end
    end
  end

  // Two-stage read: RAM output register then output register; only committed entries are fetched.
  always_comb begin
    pop         = out_vld_q && m_axis_tready;
    load_out    = ram_vld_q && (!out_vld_q || m_axis_tready);
    rd_en       = (fetch_ptr_q != commit_ptr_q) && (!ram_vld_q || load_out);
    fetch_ptr_d = rd_en ? fetch_ptr_q + PW'(1) : fetch_ptr_q;
    ram_last_d  = rd_en ? last_q[fetch_ptr_q[ADDR_WIDTH-1:0]] : ram_last_q;
    ram_vld_d   = rd_en || (ram_vld_q && !load_out);
    out_vld_d   = load_out || (out_vld_q && !pop);
    out_data_d  = load_out ? ram_rdata : out_data_q;
    out_last_d  = load_out ? ram_last_q : out_last_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({commit, pop && out_last_q})
      2'b10:   frame_cnt_d = frame_cnt_q + PW'(1);
      2'b01:   frame_cnt_d = frame_cnt_q - PW'(1);
      default: frame_cnt_d = frame_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WR_ACTIVE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      beat_cnt_q   <= '0;
      last_q       <= '0;
      frame_cnt_q  <= '0;
      good_q       <= 1'b0;
      bad_q        <= 1'b0;
      ovf_q        <= 1'b0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      last_q       <= last_d;
      frame_cnt_q  <= frame_cnt_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      ovf_q        <= ovf_d;
      ram_vld_q    <= ram_vld_d;
      ram_last_q   <= ram_last_d;
      out_vld_q    <= out_vld_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (fetch_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (ram_rdata)
  );

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tlast  = out_last_q;
  assign frame_count   = frame_cnt_q;
  assign good_frame    = good_q;
  assign bad_frame     = bad_q;
  assign overflow      = ovf_q;

endmodule

// File: doc/axis_frame_fifo.md
Name: axis_frame_fifo

Overview:
- Parametrised store-and-forward AXI-Stream frame FIFO for the Ethernet RX path, placed between MAC/CRC checker and the payload consumer.
- Buffers a frame speculatively, then on tlast either commits it, trimming TRIM_BEATS trailing beats (FCS) and re-marking tlast, or rewinds it when bad.
- Adds true simultaneous read/write, runt rejection, a selectable overflow policy and status pulses.

Parameters:
- DATA_WIDTH, 8, tdata width in bits.
- DEPTH, 1024, entries; power of two, at least 4.
- TRIM_BEATS, 4, trailing beats removed on commit; range 0 to 8.
- DROP_WHEN_FULL, 1. 1: tready held high, overflowing frame discarded. 0: backpressure on full.
- ADDR_WIDTH, $clog2(DEPTH), derived (localparam).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  write data.
- s_axis_tvalid  in  1  write valid.
- s_axis_tlast  in  1  final beat of frame (FCS included).
- s_axis_tuser  in  1  bad-frame flag, sampled only on the tlast beat.
- s_axis_tready  out  1  write ready.
- m_axis_tdata  out  DATA_WIDTH  read data.
- m_axis_tvalid  out  1  read valid.
- m_axis_tlast  out  1  final payload beat.
- m_axis_tready  in  1  read ready.
- frame_count  out  ADDR_WIDTH+1  committed, not yet fully read frames.
- good_frame  out  1  1-cycle pulse on commit.
- bad_frame  out  1  1-cycle pulse when tuser or runt discards a frame.
- overflow  out  1  1-cycle pulse when a frame is discarded for lack of space.

Behaviour:
- Reset (async assert, sync deassert):
  - Pointers, frame_count and FSM are cleared.
  - m_axis_tvalid=0; good_frame, bad_frame and overflow = 0.
  - s_axis_tready=1 when DROP_WHEN_FULL=1, else 1 once out of reset (FIFO empty).
  - Reset mid-frame discards all content, including committed frames.
- Pointers: wr_ptr (speculative), commit_ptr and rd_ptr are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH.
  - used = wr_ptr - rd_ptr.
  - full = (used == DEPTH).
- Storage:
  - Data lives in a block RAM.
  - The last flags live in a separate DEPTH-bit register vector, so commit can set the flag at an arbitrary address.
  - Each written entry clears its last flag.
- Write FSM:
  - WR_ACTIVE, on an accepted beat:
    - Write mem[wr_ptr] and increment wr_ptr.
    - Track beat count, saturating at TRIM_BEATS+1.
  - tlast beat in WR_ACTIVE:
    - If tuser=1, or frame length <= TRIM_BEATS: wr_ptr<=commit_ptr, pulse bad_frame.
    - Otherwise set last[(wr_ptr+1-TRIM_BEATS)-1], then commit_ptr<=wr_ptr+1-TRIM_BEATS and wr_ptr<=the same value. Increment frame_count and pulse good_frame.
  - Beat arriving while full:
    - DROP_WHEN_FULL=1: beat discarded, wr_ptr<=commit_ptr, pulse overflow, go to WR_DROP.
    - DROP_WHEN_FULL=0: tready=~full. If full and frame_count==0 (a frame larger than DEPTH would deadlock), tready stays 1, treat as overflow and go to WR_DROP.
  - WR_DROP: tready=1, beats discarded. On tlast, return to WR_ACTIVE with no further pulse.
  - A tlast beat that itself overflows is a single-beat drop: pulse overflow, stay in WR_ACTIVE.
- Read side:
  - Output register stage with prefetch. m_axis_tvalid is asserted only for entries below commit_ptr.
  - Latency: first beat is valid 2 cycles after the good_frame pulse (RAM read plus output register).
  - Full throughput: one beat per cycle with continuous tready.
  - tdata, tvalid and tlast hold stable while tvalid=1 and tready=0.
- frame_count:
  - +1 on commit, -1 on an output handshake carrying tlast.
  - Both in the same cycle: unchanged.
  - Never wraps, since at most DEPTH frames can be committed.
- Simultaneous read and write are always allowed. Space freed by a read is visible to the write side the next cycle.
- TRIM_BEATS=0: commit at wr_ptr+1, tlast stays on the original last beat.

Decomposition:
- Package axis_fifo_pkg: wr_state_t enum {WR_ACTIVE, WR_DROP}; function ptr_diff for the wrapped subtraction.
- One sub-module, sdp_ram, with params DATA_WIDTH and ADDR_WIDTH:
  - simple dual-port, registered read, inferred BRAM;
  - instantiated once, reused across the codebase.

Test Plan (DATA_WIDTH=8, DEPTH=16, TRIM_BEATS=4):
- 10-beat good frame 0x00..0x09, m_tready=1 -> 6 beats 0x00..0x05 out, tlast on 0x05, good_frame one pulse, frame_count returns 0.
- 8-beat frame with tuser=1 on tlast, then 6-beat good frame -> only 2 beats of the second frame appear, bad_frame pulses once, no stale data.
- 4-beat frame (length == TRIM_BEATS) -> dropped as runt, bad_frame=1, m_tvalid stays 0.
- DROP_WHEN_FULL=1, m_tready=0, 20-beat frame -> overflow pulse at beat 17, remaining beats accepted with tready=1, frame_count=0. A following 8-beat frame commits correctly.
- DROP_WHEN_FULL=0, one committed 10-beat frame, then a 12-beat frame with m_tready=0 -> tready drops at used==16. Releasing m_tready drains frame 1 (6 beats) while frame 2 completes. Output is 6+8 payload beats, frame_count peaks at 2.
- Async reset asserted mid-read of a committed frame -> all outputs 0 immediately. After deassert FIFO is empty and the next frame passes intact.
